// File: rtl/gray_pkg.sv
// Shared types and Gray/binary conversion helpers for the position tracker
// and the encoder stage that feeds it.
package gray_pkg;

   typedef enum logic [1:0] {FILL, CAPTURE, TRACK} trk_state_t;

   localparam logic [7:0] ERR_CNT_MAX = 8'd255;

   // Helpers work on a wide word; zero-extended narrower codes decode identically.
   localparam int GRAY_MAX_W = 32;
   typedef logic [GRAY_MAX_W-1:0] code_word_t;

   function automatic code_word_t gray2bin(input code_word_t g);
      code_word_t b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int k = GRAY_MAX_W-2; k >= 0; k--) begin
         b[k] = b[k+1] ^ g[k];
      end
      return b;
   endfunction

   function automatic code_word_t bin2gray(input code_word_t b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-stage synchroniser for an asynchronous Gray word; each bit has its
// own flop chain, cleared by the asynchronous reset.
module gray_sync #(
   parameter int W           = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] gray_o
);

   logic [W-1:0] stage_q [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= gray_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign gray_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_position_tracker.sv
// Synchronises a Gray-coded position, decodes it, classifies each change as
// up/down/illegal and accumulates a signed position with error telemetry.
module gray_position_tracker
   import gray_pkg::*;
#(
   parameter int W           = 3,
   parameter int POS_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     gray_in,
   input  logic             clr,
   output logic [W-1:0]     bin_o,
   output logic [POS_W-1:0] pos_o,
   output logic             dir_o,
   output logic             step_o,
   output logic             err_o,
   output logic [7:0]       err_cnt_o,
   output logic             valid_o
);

   localparam int CNT_W = $clog2(SYNC_STAGES + 1);

   logic [W-1:0]     syncGray;
   logic [W-1:0]     newBin;
   logic [W-1:0]     prevBin;
   logic [W-1:0]     delta;
   logic             isUp;
   logic             isDown;
   logic             isIllegal;

   trk_state_t       state_q, state_d;
   logic [CNT_W-1:0] fillCnt_q, fillCnt_d;
   logic [W-1:0]     prevGray_q, prevGray_d;
   logic [W-1:0]     bin_q, bin_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;
   logic [7:0]       errCnt_q, errCnt_d;
   logic             valid_q, valid_d;

   gray_sync #(
      .W           (W),
      .SYNC_STAGES (SYNC_STAGES)
   ) uSync (
      .clk    (clk),
      .rst_n  (rst_n),
      .gray_i (gray_in),
      .gray_o (syncGray)
   );

   // Modular difference of the decoded codes decides the step class; a single
   // flipped Gray bit can still be a multi-count jump and must read as illegal.
   assign newBin    = W'(gray2bin(code_word_t'(syncGray)));
   assign prevBin   = W'(gray2bin(code_word_t'(prevGray_q)));
   assign delta     = newBin - prevBin;
   assign isUp      = (delta == W'(1));
   assign isDown    = (delta == {W{1'b1}});
   assign isIllegal = (delta != '0) && !isUp && !isDown;

   always_comb begin
      state_d    = state_q;
      fillCnt_d  = fillCnt_q;
      prevGray_d = prevGray_q;
      bin_d      = bin_q;
      pos_d      = pos_q;
      dir_d      = dir_q;
      step_d     = 1'b0;
      err_d      = 1'b0;
      errCnt_d   = errCnt_q;
      valid_d    = valid_q;

      case (state_q)
         FILL: begin
            if (fillCnt_q == CNT_W'(SYNC_STAGES - 1)) begin
               fillCnt_d = '0;
               state_d   = CAPTURE;
            end else begin
               fillCnt_d = fillCnt_q + CNT_W'(1);
            end
         end

         CAPTURE: begin
            prevGray_d = syncGray;
            bin_d      = newBin;
            valid_d    = 1'b1;
            state_d    = TRACK;
         end

         TRACK: begin
            prevGray_d = syncGray;
            bin_d      = newBin;
            if (isUp) begin
               step_d = 1'b1;
               dir_d  = 1'b1;
               pos_d  = pos_q + POS_W'(1);
            end else if (isDown) begin
               step_d = 1'b1;
               dir_d  = 1'b0;
               pos_d  = pos_q - POS_W'(1);
            end else if (isIllegal) begin
               err_d = 1'b1;
               if (errCnt_q != ERR_CNT_MAX) begin
                  errCnt_d = errCnt_q + 8'd1;
               end
            end
            // Clear overrides the accumulate but leaves the step/dir report intact.
            if (clr) begin
               pos_d = '0;
            end
         end

         default: begin
            state_d = FILL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FILL;
         fillCnt_q  <= '0;
         prevGray_q <= '0;
         bin_q      <= '0;
         pos_q      <= '0;
         dir_q      <= 1'b0;
         step_q     <= 1'b0;
         err_q      <= 1'b0;
         errCnt_q   <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fillCnt_q  <= fillCnt_d;
         prevGray_q <= prevGray_d;
         bin_q      <= bin_d;
         pos_q      <= pos_d;
         dir_q      <= dir_d;
         step_q     <= step_d;
         err_q      <= err_d;
         errCnt_q   <= errCnt_d;
         valid_q    <= valid_d;
      end
   end

   assign bin_o     = bin_q;
   assign pos_o     = pos_q;
   assign dir_o     = dir_q;
   assign step_o    = step_q;
   assign err_o     = err_q;
   assign err_cnt_o = errCnt_q;
   assign valid_o   = valid_q;

endmodule

// File: tb/tb_gray_position_tracker.sv
// Self-checking bench: directed scenarios plus randomized Gray traffic compared
// against a cycle-level reference model built from a code lookup table.
module tb_gray_position_tracker;

   localparam int W     = 3;
   localparam int POS_W = 16;
   localparam int S     = 2;
   localparam int CODES = 1 << W;

   logic             clk = 1'b0;
   logic             rstN;
   logic             clrIn;
   logic [W-1:0]     grayIn;
   logic [W-1:0]     binO;
   logic [POS_W-1:0] posO;
   logic             dirO;
   logic             stepO;
   logic             errO;
   logic [7:0]       errCntO;
   logic             validO;

   int vectorCount = 0;
   int missCount   = 0;

   // Reference model state
   int               invTab [CODES];
   int               hist [$];
   int               mEdge;
   bit               mValid;
   int               mBin;
   logic [POS_W-1:0] mPos;
   bit               mDir;
   bit               mStep;
   bit               mErr;
   int               mErrCnt;

   logic [W-1:0] upSeq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                               3'b111, 3'b101, 3'b100, 3'b000};
   logic [W-1:0] downWalk [5] = '{3'b111, 3'b110, 3'b010, 3'b011, 3'b001};

   gray_position_tracker #(
      .W           (W),
      .POS_W       (POS_W),
      .SYNC_STAGES (S)
   ) dut (
      .clk       (clk),
      .rst_n     (rstN),
      .gray_in   (grayIn),
      .clr       (clrIn),
      .bin_o     (binO),
      .pos_o     (posO),
      .dir_o     (dirO),
      .step_o    (stepO),
      .err_o     (errO),
      .err_cnt_o (errCntO),
      .valid_o   (validO)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s @%0t: got %0h, expected %0h", tag, $time, observed, expected);
      end
   endtask

   task automatic modelReset();
      mEdge   = 0;
      mValid  = 0;
      mBin    = 0;
      mPos    = '0;
      mDir    = 0;
      mStep   = 0;
      mErr    = 0;
      mErrCnt = 0;
      hist.delete();
   endtask

   // One rising edge: the word seen S edges ago is judged against the one before it.
   task automatic modelEdge();
      int newB, oldB, d;
      mEdge++;
      hist.push_back(int'(grayIn));
      mStep = 0;
      mErr  = 0;
      if (mEdge == S + 1) begin
         mValid = 1;
         mBin   = invTab[hist[hist.size()-1-S]];
      end else if (mEdge > S + 1) begin
         newB = invTab[hist[hist.size()-1-S]];
         oldB = invTab[hist[hist.size()-2-S]];
         d    = (newB - oldB + CODES) % CODES;
         if (d == 1) begin
            mStep = 1;
            mDir  = 1;
            mPos  = mPos + 1'b1;
         end else if (d == CODES - 1) begin
            mStep = 1;
            mDir  = 0;
            mPos  = mPos - 1'b1;
         end else if (d != 0) begin
            mErr    = 1;
            mErrCnt = (mErrCnt < 255) ? mErrCnt + 1 : 255;
         end
         mBin = newB;
         if (clrIn) mPos = '0;
      end
      if (hist.size() > 8) void'(hist.pop_front());
   endtask

   task automatic compareAll();
      checkOutput("bin",    32'(binO),    32'(mBin));
      checkOutput("pos",    32'(posO),    32'(mPos));
      checkOutput("dir",    32'(dirO),    32'(mDir));
      checkOutput("step",   32'(stepO),   32'(mStep));
      checkOutput("err",    32'(errO),    32'(mErr));
      checkOutput("errCnt", 32'(errCntO), 32'(mErrCnt));
      checkOutput("valid",  32'(validO),  32'(mValid));
   endtask

   task automatic applyStimulus(input logic [W-1:0] g, input logic c, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         grayIn = g;
         clrIn  = c;
         @(posedge clk);
         modelEdge();
         #1;
         compareAll();
      end
      clrIn = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Bin"},    32'(binO),    32'd0);
      checkOutput({tag, "Pos"},    32'(posO),    32'd0);
      checkOutput({tag, "Dir"},    32'(dirO),    32'd0);
      checkOutput({tag, "Step"},   32'(stepO),   32'd0);
      checkOutput({tag, "Err"},    32'(errO),    32'd0);
      checkOutput({tag, "ErrCnt"}, 32'(errCntO), 32'd0);
      checkOutput({tag, "Valid"},  32'(validO),  32'd0);
   endtask

   // Reset asserted between edges; outputs must clear before any further edge.
   task automatic asyncReset();
      @(posedge clk);
      #3;
      rstN = 1'b0;
      #1;
      checkAllZero("asyncRst");
      modelReset();
      repeat (2) @(posedge clk);
      #2;
      rstN = 1'b1;
   endtask

   initial begin
      int curBin;
      int hold;
      logic [W-1:0] g;
      logic c;

      for (int i = 0; i < CODES; i++) invTab[i ^ (i >> 1)] = i;

      rstN   = 1'b0;
      grayIn = '0;
      clrIn  = 1'b0;
      modelReset();
      #1;
      checkAllZero("reset");
      repeat (2) @(posedge clk);
      #2;
      rstN = 1'b1;

      // Prime on a constant 000
      applyStimulus(3'b000, 1'b0, 3);
      checkOutput("primeValid", 32'(validO), 32'd1);
      applyStimulus(3'b000, 1'b0, 2);

      // Full up sweep
      foreach (upSeq[i]) applyStimulus(upSeq[i], 1'b0, 4);
      checkOutput("sweepPos", 32'(posO), 32'd8);
      checkOutput("sweepDir", 32'(dirO), 32'd1);

      applyStimulus(3'b000, 1'b1, 1);
      checkOutput("clrPos", 32'(posO), 32'd0);

      // Down across zero
      applyStimulus(3'b100, 1'b0, 3);
      checkOutput("downPos", 32'(posO), 32'hFFFF);
      checkOutput("downBin", 32'(binO), 32'd7);
      checkOutput("downDir", 32'(dirO), 32'd0);
      applyStimulus(3'b101, 1'b0, 3);
      checkOutput("down2Pos", 32'(posO), 32'hFFFE);
      foreach (downWalk[i]) applyStimulus(downWalk[i], 1'b0, 3);
      checkOutput("walkPos", 32'(posO), 32'hFFF9);

      // Single-bit Gray change that is a multi-count jump
      applyStimulus(3'b101, 1'b0, 3);
      checkOutput("illErrCnt", 32'(errCntO), 32'd1);
      checkOutput("illPos",    32'(posO),    32'hFFF9);
      checkOutput("illBin",    32'(binO),    32'd6);
      applyStimulus(3'b100, 1'b0, 3);
      checkOutput("postIllPos", 32'(posO), 32'hFFFA);
      checkOutput("postIllDir", 32'(dirO), 32'd1);

      // Saturate the error counter
      for (int i = 0; i < 150; i++) begin
         applyStimulus(3'b001, 1'b0, 2);
         applyStimulus(3'b101, 1'b0, 2);
      end
      checkOutput("satErrCnt", 32'(errCntO), 32'd255);

      // Clear coincident with an up step
      applyStimulus(3'b100, 1'b0, 2);
      applyStimulus(3'b100, 1'b1, 1);
      checkOutput("clrStepPos",  32'(posO),  32'd0);
      checkOutput("clrStepStep", 32'(stepO), 32'd1);
      checkOutput("clrStepDir",  32'(dirO),  32'd1);

      // Reset mid-sweep, then re-prime on a non-zero code
      applyStimulus(3'b000, 1'b0, 2);
      applyStimulus(3'b001, 1'b0, 1);
      asyncReset();
      applyStimulus(3'b001, 1'b0, 6);
      checkOutput("reprimeBin",   32'(binO),   32'd1);
      checkOutput("reprimePos",   32'(posO),   32'd0);
      checkOutput("reprimeValid", 32'(validO), 32'd1);

      // Randomized traffic: mostly legal steps, some jumps, clears and resets
      curBin = 1;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: curBin = (curBin + 1) % CODES;
            4, 5, 6, 7: curBin = (curBin + CODES - 1) % CODES;
            default:    curBin = int'($urandom_range(0, CODES - 1));
         endcase
         g    = W'(curBin ^ (curBin >> 1));
         hold = int'($urandom_range(1, 4));
         c    = ($urandom_range(0, 19) == 0);
         applyStimulus(g, c, 1);
         if (hold > 1) applyStimulus(g, 1'b0, hold - 1);
         if ($urandom_range(0, 99) == 0) asyncReset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
